// File: rtl/regfl_alu_seq.sv
// Load-op-store sequencer that drives a 4x8 register file: reads two operands, adds/subtracts (one's complement), writes back.
// Latency: start sampled at edge 0, write-back on edge 4 with done high after edge 4; one command per 5 cycles.
// Backpressure: none queued; start is only sampled in IDLE and ignored while busy.
//
// Ports:
//   clk, rst            - system clock, asynchronous active-high reset
//   start, op           - command strobe; op 0 = a+b, 1 = a+~b (one's complement)
//   src_a, src_b, dst   - operand and destination register addresses
//   busy, done          - busy while not IDLE; done pulses one cycle after write-back
//   rf_rd_addr/rf_rd_data                - register file combinational read port
//   rf_wr_e/rf_wr_addr/rf_wr_data        - register file write port
//
// Optional build macro: REGFL_ALU_ZERO_NORM_EN
//   When defined, an all-ones result (negative zero) is written as all zeros.

module regfl_alu_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_e,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t            state_q,      state_d;
  logic              op_q,         op_d;
  logic [ADDR_W-1:0] src_b_q,      src_b_d;
  logic [ADDR_W-1:0] dst_q,        dst_d;
  logic [DATA_W-1:0] opa_q,        opa_d;
  logic [DATA_W-1:0] opb_q,        opb_d;
  logic [ADDR_W-1:0] rd_addr_q,    rd_addr_d;
  logic              wr_e_q,       wr_e_d;
  logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,    wr_data_d;
  logic              done_q,       done_d;
  logic              busy_q,       busy_d;

  // One's-complement datapath. Subtract is a + ~b; the carry out of the
  // raw sum is folded back into bit 0 (end-around carry). Adding a single
  // carry to a sum that itself carried can never carry again, so a DATA_W
  // wide second add is sufficient.
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum_raw;
  logic [DATA_W-1:0] sum_eac;
  logic [DATA_W-1:0] result;

  always_comb begin
    b_eff   = op_q ? ~opb_q : opb_q;
    sum_raw = {1'b0, opa_q} + {1'b0, b_eff};
    sum_eac = sum_raw[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, sum_raw[DATA_W]};
`ifdef REGFL_ALU_ZERO_NORM_EN
    // Fold negative zero (all ones) onto positive zero.
    result  = (&sum_eac) ? '0 : sum_eac;
`else
    result  = sum_eac;
`endif
  end

  // Next-state logic. Every output comes straight from a flop, so the
  // register file sees glitch-free address/enable lines.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_b_d   = src_b_q;
    dst_d     = dst_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rd_addr_d = rd_addr_q;
    wr_e_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          src_b_d   = src_b;
          dst_d     = dst;
          rd_addr_d = src_a;
          state_d   = S_RD_A;
        end
      end
      S_RD_A: begin
        // rf_rd_addr has pointed at src_a for this whole cycle.
        opa_d     = rf_rd_data;
        rd_addr_d = src_b_q;
        state_d   = S_RD_B;
      end
      S_RD_B: begin
        opb_d   = rf_rd_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Both operands are captured before the write, so dst aliasing
        // a source always uses the old value.
        wr_data_d = result;
        wr_addr_d = dst_q;
        wr_e_d    = 1'b1;
        state_d   = S_WB;
      end
      S_WB: begin
        // Register file captures on the edge that ends this state.
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Asynchronous reset clears rf_wr_e immediately, so an in-flight
  // command can never complete a partial write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 1'b0;
      src_b_q   <= '0;
      dst_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      rd_addr_q <= '0;
      wr_e_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_b_q   <= src_b_d;
      dst_q     <= dst_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rd_addr_q <= rd_addr_d;
      wr_e_q    <= wr_e_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rf_rd_addr = rd_addr_q;
  assign rf_wr_e    = wr_e_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;

endmodule

// File: doc/regfl_alu_seq.md
Name: regfl_alu_seq

Overview:
- Multi-cycle sequencer that sits directly upstream of the 4x8 register file (regfl_4x8) and drives all of its ports.
- On each command it reads two source registers through the file's single combinational read port and combines them with a one's-complement adder (end-around carry, add or subtract).
- It then writes the result back into a destination register through the file's write port.
- This gives the register file its first autonomous producer/consumer: a load-op-store engine.

Parameters:
- DATA_W, 8, operand/result width; must equal the register-file data width.
- ADDR_W, 2, register address width; 4 registers.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- op  input  1  0 = add (a+b), 1 = subtract (a+~b); one's-complement arithmetic.
- src_a  input  ADDR_W  first operand register.
- src_b  input  ADDR_W  second operand register.
- dst  input  ADDR_W  destination register.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when the write-back has completed.
- rf_rd_addr  output  ADDR_W  to the register file rd_addr.
- rf_rd_data  input  DATA_W  from the register file rd_data; combinational read.
- rf_wr_e  output  1  to the register file wr_e.
- rf_wr_addr  output  ADDR_W  to the register file wr_addr.
- rf_wr_data  output  DATA_W  to the register file wr_data.

Behaviour:
- Reset values: busy=0, done=0, rf_wr_e=0, rf_rd_addr=0, rf_wr_addr=0, rf_wr_data=0, internal operands=0, state=IDLE.
- Reset is asynchronous: rf_wr_e drops immediately on rst, even mid-operation. No partial write occurs; an in-flight command is abandoned with no done pulse.
- States: IDLE -> RD_A -> RD_B -> EXEC -> WB -> IDLE. All outputs are registered.
- IDLE:
  - If start=1, latch op/src_a/src_b/dst, set rf_rd_addr<=src_a, go to RD_A.
  - If start=0, stay.
  - done is cleared here on the cycle after its pulse.
- RD_A: opa<=rf_rd_data; rf_rd_addr<=src_b; go to RD_B.
- RD_B: opb<=rf_rd_data; go to EXEC.
- EXEC:
  - b' = op ? ~opb : opb.
  - s = {1'b0,opa} + {1'b0,b'} (DATA_W+1 bits).
  - rf_wr_data <= s[DATA_W-1:0] + s[DATA_W]; the end-around carry never produces a second carry.
  - rf_wr_addr <= dst; rf_wr_e <= 1; go to WB.
- WB: rf_wr_e is high for exactly this one cycle, so the register file captures on the edge ending WB. That edge sets rf_wr_e<=0, done<=1, and returns to IDLE.
- Latency:
  - start is sampled at edge 0; done is high after edge 4.
  - The result is visible on a register-file read after edge 4.
  - Throughput is one command per 5 cycles; a new start is accepted in the cycle done is high.
- start while busy is ignored; it is not queued.
- Aliasing is legal: dst may equal src_a and/or src_b, and src_a may equal src_b. Operands are captured before write-back, so old values are always used.
- Zero result: -0 (all ones) is produced as-is unless the optional feature is compiled in.

Optional Feature:
- Macro: REGFL_ALU_ZERO_NORM_EN.
- Defined: in EXEC, a result equal to all ones (negative zero) is replaced by all zeros before rf_wr_data is registered. Latency is unchanged.
- Undefined: all-ones results are written unchanged.

Test Plan:
- Reset mid-op: preload R0=8'h05, R1=8'h03; start add R0+R1->R2; assert rst in EXEC -> rf_wr_e=0 immediately, no done, R2 unchanged, busy=0.
- Add: R0=8'h05, R1=8'h03, op=0, dst=R2 -> done after 4 edges, R2=8'h08, rf_wr_e high for exactly 1 cycle.
- End-around carry: R0=8'hFF, R1=8'h01 add -> R2=8'h01. Subtract: R0=8'h05, R1=8'h03, op=1 -> R2=8'h02.
- Negative zero: R1=8'h03, R1-R1->R3 -> R3=8'hFF with macro undefined; R3=8'h00 with REGFL_ALU_ZERO_NORM_EN.
- Aliasing and back-to-back: R0=8'h10; R0+R0->R0, then start again in the done cycle -> R0=8'h20, then 8'h40. A start pulsed during RD_B is ignored: exactly 2 done pulses total.
